// File: rtl/mult4_product_accumulator_if.sv
// Valid/ready product stream in, registered group result out, for mult4_product_accumulator.
// The accumulator drives the slave modport; the producer/sink side uses master.
interface mult4_product_accumulator_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_p;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_p, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_p, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/mult4_product_accumulator.sv
// Sums groups of up to N_TERMS 8-bit products into an ACC_W-bit result with count and overflow.
// Define MULT4_ACC_SAT_EN to saturate the sum on overflow; by default it wraps modulo 2^ACC_W.
module mult4_product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    mult4_product_accumulator_if.slave     bus
);
    localparam int         SUM_W    = ACC_W + 1;
    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc;
    logic [7:0]         cnt;
    logic               ovf;
    logic [ACC_W-1:0]   sum_q;
    logic [7:0]         count_q;
    logic               ovf_q;

    logic               accept, xfer, close;
    logic [SUM_W-1:0]   sum_ext;
    logic               ovf_next;
    logic [ACC_W-1:0]   acc_next;

    // Handshake outputs decode the state register only, so they never see in_valid or out_ready.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign xfer     = bus.out_valid && bus.out_ready;
    assign close    = accept && ((cnt == LAST_CNT) || bus.in_last);

    assign sum_ext  = {1'b0, acc} + SUM_W'(bus.in_p);
    assign ovf_next = ovf | sum_ext[ACC_W];

`ifdef MULT4_ACC_SAT_EN
    // Once ovf is set the sum is pinned at all-ones for the rest of the group.
    assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (close) state_next = HOLD;
            HOLD:  if (xfer)  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (close) begin
                sum_q   <= acc_next;
                count_q <= cnt + 8'd1;
                ovf_q   <= ovf_next;
                acc     <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
            end else begin
                acc     <= acc_next;
                cnt     <= cnt + 8'd1;
                ovf     <= ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_mult4_product_accumulator.sv
// Directed bench for mult4_product_accumulator: a 16-bit instance for grouping/handshake
// behaviour and a 9-bit instance for overflow, with expectations following MULT4_ACC_SAT_EN.
module tb_mult4_product_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult4_product_accumulator_if #(.ACC_W(16)) bus_a ();
    mult4_product_accumulator_if #(.ACC_W(9))  bus_b ();

    mult4_product_accumulator #(.N_TERMS(4), .ACC_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mult4_product_accumulator #(.N_TERMS(4), .ACC_W(9))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Present one product on bus_a and return #1 after the edge that accepted it.
    task automatic send(input logic [7:0] p, input logic last);
        int waited = 0;
        bus_a.in_valid = 1'b1;
        bus_a.in_p     = p;
        bus_a.in_last  = last;
        while (!bus_a.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) check("accept_timeout", 32'(bus_a.in_ready), 32'd1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int sum, input int count, input logic ovf);
        check({tag, "_valid"}, 32'(bus_a.out_valid), 32'd1);
        check({tag, "_sum"},   32'(bus_a.out_sum),   32'(sum));
        check({tag, "_count"}, 32'(bus_a.out_count), 32'(count));
        check({tag, "_ovf"},   32'(bus_a.out_ovf),   32'(ovf));
    endtask

    initial begin
        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_p = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_p = '0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b1;

        #12;
        check("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_sum",   32'(bus_a.out_sum),   32'd0);
        check("rst_out_count", 32'(bus_a.out_count), 32'd0);
        check("rst_out_ovf",   32'(bus_a.out_ovf),   32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Full group, back-to-back, sink always ready.
        for (int i = 0; i < 4; i++) send(8'd225, 1'b0);
        check_result("full", 900, 4, 1'b0);
        check("full_in_ready_low", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk); #1;
        check("full_valid_one_cycle", 32'(bus_a.out_valid), 32'd0);
        check("full_in_ready_back",   32'(bus_a.in_ready),  32'd1);

        // Early close on in_last.
        send(8'd6, 1'b0);
        send(8'd10, 1'b1);
        check_result("early", 16, 2, 1'b0);
        @(posedge clk); #1;

        // Backpressure: result held 5 cycles while a product waits on the input.
        bus_a.out_ready = 1'b0;
        send(8'd7, 1'b0);
        send(8'd8, 1'b1);
        bus_a.in_valid = 1'b1;
        bus_a.in_p     = 8'd99;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
            check_result("bp", 15, 2, 1'b0);
            @(posedge clk); #1;
        end
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        check("bp_xfer_valid",  32'(bus_a.out_valid), 32'd0);
        check("bp_xfer_ready",  32'(bus_a.in_ready),  32'd1);
        check("bp_sum_kept",    32'(bus_a.out_sum),   32'd15);
        send(8'd1, 1'b1);
        check_result("bp_next", 1, 1, 1'b0);
        @(posedge clk); #1;

        // Reset mid-group discards the partial sum.
        send(8'd100, 1'b0);
        send(8'd50, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("mrst_out_sum",   32'(bus_a.out_sum),   32'd0);
        check("mrst_out_count", 32'(bus_a.out_count), 32'd0);
        check("mrst_out_ovf",   32'(bus_a.out_ovf),   32'd0);
        check("mrst_in_ready",  32'(bus_a.in_ready),  32'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        check_result("post_rst", 10, 4, 1'b0);
        @(posedge clk); #1;

        // Gaps between products; in_last on the 4th coincides with the count limit.
        for (int i = 1; i <= 4; i++) begin
            repeat ($urandom_range(1, 3)) begin
                check("gap_no_valid", 32'(bus_a.out_valid), 32'd0);
                @(posedge clk); #1;
            end
            send(8'(i), (i == 4));
            if (i < 4) check("gap_early_valid", 32'(bus_a.out_valid), 32'd0);
        end
        check_result("gaps", 10, 4, 1'b0);
        @(posedge clk); #1;
        check("gaps_single_close", 32'(bus_a.out_valid), 32'd0);
        send(8'd5, 1'b1);
        check_result("after_gaps", 5, 1, 1'b0);
        @(posedge clk); #1;

        // Overflow on the 9-bit instance: 225*4 = 900 exceeds 511.
        bus_b.in_valid = 1'b1;
        bus_b.in_p     = 8'd225;
        repeat (4) @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
        check("ovf_valid", 32'(bus_b.out_valid), 32'd1);
        check("ovf_count", 32'(bus_b.out_count), 32'd4);
        check("ovf_flag",  32'(bus_b.out_ovf),   32'd1);
`ifdef MULT4_ACC_SAT_EN
        check("ovf_sum",   32'(bus_b.out_sum),   32'd511);
`else
        check("ovf_sum",   32'(bus_b.out_sum),   32'd388);
`endif
        @(posedge clk); #1;
        check("ovf_xfer", 32'(bus_b.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult4_product_accumulator.md
# mult4_product_accumulator

Sequential stage directly downstream of the 4-bit composed multipliers. It accepts a stream of 8-bit products over a valid/ready handshake and sums a group of them into a wider accumulator, producing dot-product style results. It emits one registered sum per group, together with a term count and an overflow flag. It sits between any `mult4_*` combinational multiplier (its `P` output drives `in_p`) and the result sink.

## Interface
- `N_TERMS`, default 4: products per group; legal range 1..255.
- `ACC_W`, default 16: accumulator and result width; must be at least 9.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_p` holds a product.
- `in_ready` output 1: block can accept a product this cycle.
- `in_p` input 8: unsigned product, 0..225.
- `in_last` input 1: qualified by the accept; closes the group early.
- `out_valid` output 1: result registers hold a finished group.
- `out_ready` input 1: sink takes the result.
- `out_sum` output `ACC_W`: group sum.
- `out_count` output 8: number of products in the group, 1..`N_TERMS`.
- `out_ovf` output 1: the accumulator exceeded 2^`ACC_W`-1 during the group.

## Operation
- Accept condition: `in_valid` && `in_ready`. Output transfer condition: `out_valid` && `out_ready`.
- State ACCUM:
  - `in_ready`=1.
  - On each accept, `acc` <= `acc` + zero-extended `in_p`, and `cnt` <= `cnt`+1.
  - The group closes when an accept has `cnt`==`N_TERMS`-1 or `in_last`=1.
  - On close, the final sum (including the current product), count and ovf are loaded into the `out_*` registers. `acc`, `cnt` and the internal ovf clear. Next state is HOLD.
- State HOLD:
  - `in_ready`=0 and `out_valid`=1.
  - On an output transfer, `out_valid` <= 0 and the next state is ACCUM.
  - `out_sum`, `out_count` and `out_ovf` stay stable while HOLD persists.
- `out_sum`, `out_count` and `out_ovf` keep their last values after transfer. They are don't-care while `out_valid`=0, but must not change except on a close.
- Arithmetic: the sum is unsigned at `ACC_W`+1 bits internally. Bit `ACC_W` set on any add sets ovf, which is sticky until the group closes. Result handling on overflow is set by the Configuration macro.
- `in_p` values above 225 are summed as given; there is no range check.
- `in_last` with `cnt`==`N_TERMS`-1 is a single close, not two.
- `N_TERMS`=1: every accept closes a group.
- Reset mid-group: the partial sum is discarded and no result is emitted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0. State is ACCUM with `acc`=0, `cnt`=0.
- Latency: `out_valid` rises on the clock edge of the closing accept and is visible the following cycle.
- `in_ready` drops in that same cycle. The first cycle after a transfer in HOLD has `in_ready`=1.
- Throughput: at most `N_TERMS` products per `N_TERMS`+1 cycles. A HOLD always lasts at least one cycle, and there is no same-cycle transfer and accept.
- `in_ready` is a registered function of state only. It does not depend combinationally on `in_valid` or `out_ready`.
- `out_valid` never deasserts without a transfer, except on `rst`.

## Configuration
- `MULT4_ACC_SAT_EN` defined: on overflow, `acc` clamps to 2^`ACC_W`-1 and stays there for the rest of the group. `out_sum` is then all-ones and `out_ovf`=1.
- `MULT4_ACC_SAT_EN` undefined: the sum wraps modulo 2^`ACC_W` and `out_ovf`=1 flags the wrap.
- `out_ovf` behaves identically in both builds.

## Test plan
- Full group: `N_TERMS`=4, `ACC_W`=16, products 225,225,225,225 back-to-back with `out_ready`=1 → `out_sum`=900 (0x0384), `out_count`=4, `out_ovf`=0. `out_valid` lasts one cycle, and `in_ready` is 0 for that cycle only.
- Early close: products 6 then 10 with `in_last` on the 10 → `out_sum`=16, `out_count`=2. The next group starts from 0.
- Backpressure: hold `out_ready`=0 for 5 cycles after a close, with `in_valid`=1 throughout → `in_ready`=0 and `out_*` stable for all 5 cycles, and no products consumed. The transfer occurs on the cycle `out_ready`=1.
- Overflow: `ACC_W`=9, four products of 225 →
  - without the macro: `out_sum`=388, `out_ovf`=1;
  - with `MULT4_ACC_SAT_EN`: `out_sum`=511, `out_ovf`=1.
- Reset mid-group: accept 100 and 50, assert `rst` asynchronously between edges, release, then send 1,2,3,4 → all outputs are 0 during reset, and the result is `out_sum`=10, `out_count`=4.
- Gaps: products 1,2,3,4 with `in_valid` low for random cycles between them → `out_sum`=10, with `out_valid` only after the fourth accept.
